// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key expansion slice.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    EXPAND
  } state_t;

  typedef logic [31:0] word_t;

  localparam logic [7:0]  RCON_INIT      = 8'h01;
  localparam int unsigned NUM_ROUNDS_128 = 10;

  // GF(2^8) multiply-by-two, used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key schedule <-> cipher round FSM handshake bundle.
interface aes_key_schedule_if;

  logic         load;
  logic [127:0] key;
  logic         keyUpdate;
  logic [127:0] roundKey;
  logic [3:0]   keyRound;
  logic         keyReady;
  logic         keyDone;

  // Cipher round FSM side
  modport master (
    output load, key, keyUpdate,
    input  roundKey, keyRound, keyReady, keyDone
  );

  // Key schedule side
  modport slave (
    input  load, key, keyUpdate,
    output roundKey, keyRound, keyReady, keyDone
  );

endinterface

// File: rtl/aes_sbox_sync.sv
// 256x8 AES forward S-box as a synchronous ROM with registered output.
module aes_sbox_sync (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Registered ROM read: one cycle from address to data.
  always_ff @(posedge clk) begin
    data <= SBOX[addr];
  end

endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 key expansion; one round key per request, S-box
// bytes looked up serially through a single synchronous ROM.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_128
) (
  input logic               clk,
  input logic               reset,
  aes_key_schedule_if.slave ks
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t       state_q;
  logic [127:0] roundKey_q;
  logic [3:0]   keyRound_q;
  logic         keyReady_q;
  logic [7:0]   rcon_q;
  word_t        subWord_q;
  logic [2:0]   byteIdx_q;

  word_t        w0, w1, w2, w3, rotW;
  word_t        n0, n1, n2, n3;
  logic [127:0] roundKey_d;
  logic [7:0]   sboxAddr;
  logic [7:0]   sboxData;

  // Next round key from the current key, collected SubWord and rcon.
  always_comb begin
    {w0, w1, w2, w3} = roundKey_q;
    rotW       = {w3[23:0], w3[31:24]};
    n0         = w0 ^ subWord_q ^ {rcon_q, 24'h0};
    n1         = w1 ^ n0;
    n2         = w2 ^ n1;
    n3         = w3 ^ n2;
    roundKey_d = {n0, n1, n2, n3};
  end

  // Rotated bytes issued MSB first; index 4 only drains the ROM pipeline.
  always_comb begin
    sboxAddr = '0;
    unique case (byteIdx_q[1:0])
      2'd0: sboxAddr = rotW[31:24];
      2'd1: sboxAddr = rotW[23:16];
      2'd2: sboxAddr = rotW[15:8];
      2'd3: sboxAddr = rotW[7:0];
      default: sboxAddr = '0;
    endcase
  end

  aes_sbox_sync u_sbox (
    .clk  (clk),
    .addr (sboxAddr),
    .data (sboxData)
  );

  // Control FSM and registered outputs; load overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      roundKey_q <= '0;
      keyRound_q <= '0;
      keyReady_q <= 1'b0;
      rcon_q     <= RCON_INIT;
      subWord_q  <= '0;
      byteIdx_q  <= '0;
    end else if (ks.load) begin
      state_q    <= IDLE;
      roundKey_q <= ks.key;
      keyRound_q <= '0;
      keyReady_q <= 1'b1;
      rcon_q     <= RCON_INIT;
      byteIdx_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ks.keyUpdate && keyReady_q && (keyRound_q < LAST_ROUND)) begin
            keyReady_q <= 1'b0;
            byteIdx_q  <= '0;
            state_q    <= SUB;
          end
        end
        SUB: begin
          // ROM data lags the address by one step, so capture from index 1.
          if (byteIdx_q != 3'd0) begin
            subWord_q <= {subWord_q[23:0], sboxData};
          end
          if (byteIdx_q == 3'd4) begin
            byteIdx_q <= '0;
            state_q   <= EXPAND;
          end else begin
            byteIdx_q <= byteIdx_q + 3'd1;
          end
        end
        EXPAND: begin
          roundKey_q <= roundKey_d;
          keyRound_q <= keyRound_q + 4'd1;
          rcon_q     <= xtime(rcon_q);
          keyReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ks.roundKey = roundKey_q;
  assign ks.keyRound = keyRound_q;
  assign ks.keyReady = keyReady_q;
  assign ks.keyDone  = keyReady_q && (keyRound_q == LAST_ROUND);

endmodule
